p2s_lanes: RTL and testbench

P2S_LANES -- requirements
Module: p2s_lanes

---
 rtl/p2s_lanes.sv | 146 ++++++++++++++
 tb/tb_p2s_lanes.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/p2s_lanes.sv
// p2s_lanes: multi-lane parallel-to-serial converter with holding and shift registers (optional P2S_IDLE_PATTERN_EN)
module p2s_lanes #(
   parameter int LANES = 4,
   parameter int WIDTH = 8,
   parameter int MSB_FIRST = 1,
   parameter logic [WIDTH-1:0] IDLE_WORD = WIDTH'(8'hBC)
) (
   input  logic                   CLK,
   input  logic                   reset,
   input  logic                   ENB,
   input  logic [LANES*WIDTH-1:0] data_in,
   input  logic                   valid_in,
   output logic                   ready_in,
   output logic [LANES-1:0]       data_out,
   output logic                   valid_out,
   output logic                   sof,
   output logic                   busy
);
   localparam int CW = $clog2(WIDTH);
   localparam int LW = LANES * WIDTH;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   localparam logic [LW-1:0] IDLE_VEC = {LANES{IDLE_WORD}};
   typedef enum logic {IDLE, SHIFT} state_t;
   state_t state_q, state_d;
   logic [LW-1:0] hold_q, hold_d, shift_q, shift_d;
   logic full_q, full_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [LANES-1:0] dout_d;
   logic vout_d, sof_d;
   logic last, xfer, accept;
`ifdef P2S_IDLE_PATTERN_EN
   logic idle_q, idle_d;
`endif
   function automatic logic [LANES-1:0] first_bits(input logic [LW-1:0] w);
      logic [LANES-1:0] b;
      for (int i = 0; i < LANES; i++)
         b[i] = (MSB_FIRST != 0) ? w[i*WIDTH + WIDTH - 1] : w[i*WIDTH];
      return b;
   endfunction
   function automatic logic [LW-1:0] advance(input logic [LW-1:0] w);
      logic [LW-1:0] r;
      for (int i = 0; i < LANES; i++)
         r[i*WIDTH +: WIDTH] = (MSB_FIRST != 0) ? {w[i*WIDTH +: WIDTH-1], 1'b0}
                                                 : {1'b0, w[i*WIDTH+1 +: WIDTH-1]};
      return r;
   endfunction
   assign last = cnt_q == LAST;
`ifdef P2S_IDLE_PATTERN_EN
   assign xfer = ENB & full_q & ((state_q == IDLE) ? (!idle_q | last) : last);
`else
   assign xfer = ENB & full_q & ((state_q == IDLE) | last);
`endif
   assign ready_in = ENB & !reset & (!full_q | xfer);
   assign accept = ready_in & valid_in;
   assign busy = full_q | (state_q == SHIFT);
   // next-state: transfer, bit stepping, end of word, holding register fill/drain; everything holds while ENB is low
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      shift_d = shift_q;
      hold_d = hold_q;
      full_d = full_q;
      dout_d = data_out;
      vout_d = valid_out;
      sof_d = sof;
`ifdef P2S_IDLE_PATTERN_EN
      idle_d = idle_q;
`endif
      if (ENB) begin
         sof_d = 1'b0;
         if (xfer) begin
            state_d = SHIFT;
            cnt_d = '0;
            shift_d = advance(hold_q);
            dout_d = first_bits(hold_q);
            vout_d = 1'b1;
            sof_d = 1'b1;
`ifdef P2S_IDLE_PATTERN_EN
            idle_d = 1'b0;
`endif
         end else if (state_q == SHIFT && !last) begin
            cnt_d = cnt_q + CW'(1);
            shift_d = advance(shift_q);
            dout_d = first_bits(shift_q);
         end else if (state_q == SHIFT) begin
            state_d = IDLE;
            vout_d = 1'b0;
`ifdef P2S_IDLE_PATTERN_EN
            cnt_d = '0;
            shift_d = advance(IDLE_VEC);
            dout_d = first_bits(IDLE_VEC);
            idle_d = 1'b1;
`else
            shift_d = IDLE_VEC;
            dout_d = '0;
`endif
         end
`ifdef P2S_IDLE_PATTERN_EN
         else if (!idle_q || last) begin
            cnt_d = '0;
            shift_d = advance(IDLE_VEC);
            dout_d = first_bits(IDLE_VEC);
            idle_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CW'(1);
            shift_d = advance(shift_q);
            dout_d = first_bits(shift_q);
         end
`endif
         if (accept) begin
            hold_d = data_in;
            full_d = 1'b1;
         end else if (xfer) begin
            full_d = 1'b0;
         end
      end
   end
   // state register with synchronous reset clearing every register and output
   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q <= '0;
         shift_q <= '0;
         hold_q <= '0;
         full_q <= 1'b0;
         data_out <= '0;
         valid_out <= 1'b0;
         sof <= 1'b0;
`ifdef P2S_IDLE_PATTERN_EN
         idle_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         shift_q <= shift_d;
         hold_q <= hold_d;
         full_q <= full_d;
         data_out <= dout_d;
         valid_out <= vout_d;
         sof <= sof_d;
`ifdef P2S_IDLE_PATTERN_EN
         idle_q <= idle_d;
`endif
      end
   end
endmodule

// File: tb/tb_p2s_lanes.sv
// tb_p2s_lanes: randomized self-checking bench for p2s_lanes against a word-schedule reference model
module tb_p2s_lanes;
   localparam int L = 4;
   localparam int W = 8;
   localparam int MSB = 1;
   localparam int LW = L * W;
   logic CLK = 1'b0, reset = 1'b1, ENB = 1'b0, valid_in = 1'b0;
   logic [LW-1:0] data_in = '0;
   logic ready_in, valid_out, sof, busy;
   logic [L-1:0] data_out;
   int total = 0, bad = 0;
   int n = 0, next_free = 0;
   int s_q[$];
   logic [LW-1:0] w_q[$];
   logic exp_rdy, exp_v = 1'b0, exp_sof = 1'b0, exp_busy = 1'b0;
   logic [L-1:0] exp_dout = '0;
   p2s_lanes #(.LANES(L), .WIDTH(W), .MSB_FIRST(MSB), .IDLE_WORD(8'hBC)) dut (
      .CLK(CLK), .reset(reset), .ENB(ENB), .data_in(data_in), .valid_in(valid_in),
      .ready_in(ready_in), .data_out(data_out), .valid_out(valid_out), .sof(sof), .busy(busy)
   );
   always #5 CLK = ~CLK;
   task automatic drive(input logic en, input logic v, input logic [LW-1:0] d, input logic r);
      @(negedge CLK);
      ENB = en;
      valid_in = v;
      data_in = d;
      reset = r;
      #1;
      exp_rdy = en & !r & (s_q.size() == 0 || s_q[s_q.size()-1] <= n);
   endtask
   task automatic tick();
      logic [LW-1:0] w;
      int s, j;
      @(posedge CLK);
      if (reset) begin
         s_q.delete();
         w_q.delete();
         next_free = 0;
         exp_dout = '0;
         exp_v = 1'b0;
         exp_sof = 1'b0;
         exp_busy = 1'b0;
      end else if (ENB) begin
         if (valid_in && exp_rdy) begin
            s = (n + 1 > next_free) ? n + 1 : next_free;
            s_q.push_back(s);
            w_q.push_back(data_in);
            next_free = s + W;
         end
         exp_dout = '0;
         exp_v = 1'b0;
         exp_sof = 1'b0;
         exp_busy = 1'b0;
         foreach (s_q[k]) begin
            if (s_q[k] <= n && n < s_q[k] + W) begin
               j = n - s_q[k];
               w = w_q[k];
               for (int i = 0; i < L; i++) exp_dout[i] = w[i*W + ((MSB != 0) ? W - 1 - j : j)];
               exp_v = 1'b1;
               exp_sof = (j == 0);
            end
            if (s_q[k] + W - 1 >= n) exp_busy = 1'b1;
         end
         while (s_q.size() > 0 && s_q[0] + W <= n) begin
            void'(s_q.pop_front());
            void'(w_q.pop_front());
         end
         n++;
      end
      #1;
   endtask
   task automatic test_reset();
      for (int c = 0; c < 3; c++) begin
         drive(1'b1, 1'b1, $urandom, 1'b1);
         total++; if (ready_in !== 1'b0) begin bad++; $display("FAIL reset ready: got %b want 0", ready_in); end
         tick();
         total++; if ({data_out, valid_out, sof, busy} !== 7'b0) begin bad++; $display("FAIL reset out: got %b want 0", {data_out, valid_out, sof, busy}); end
      end
      drive(1'b1, 1'b0, '0, 1'b0);
      total++; if (ready_in !== exp_rdy) begin bad++; $display("FAIL reset ready_after: got %b want %b", ready_in, exp_rdy); end
      tick();
`ifndef P2S_IDLE_PATTERN_EN
      total++; if ({data_out, valid_out, sof, busy} !== {exp_dout, exp_v, exp_sof, exp_busy}) begin bad++; $display("FAIL reset idle_out: got %b want %b", {data_out, valid_out, sof, busy}, {exp_dout, exp_v, exp_sof, exp_busy}); end
`endif
   endtask
   task automatic test_single_word();
      logic [7:0] l3 = 8'b10100101, l0 = 8'b00000001;
      int vcnt = 0;
      drive(1'b1, 1'b1, 32'hA53CFF01, 1'b0);
      total++; if (ready_in !== exp_rdy) begin bad++; $display("FAIL single ready: got %b want %b", ready_in, exp_rdy); end
      tick();
      for (int c = 1; c <= 10; c++) begin
         drive(1'b1, 1'b0, '0, 1'b0);
         tick();
         total++; if ({data_out, valid_out, sof, busy} !== {exp_dout, exp_v, exp_sof, exp_busy}) begin bad++; $display("FAIL single out c=%0d: got %b want %b", c, {data_out, valid_out, sof, busy}, {exp_dout, exp_v, exp_sof, exp_busy}); end
         if (c <= 8) begin
            total++; if ({data_out[3], data_out[0], sof} !== {l3[8-c], l0[8-c], c == 1}) begin bad++; $display("FAIL single lanes c=%0d: got %b want %b", c, {data_out[3], data_out[0], sof}, {l3[8-c], l0[8-c], c == 1}); end
         end
         if (valid_out) vcnt++;
      end
      total++; if (vcnt !== 8) begin bad++; $display("FAIL single vcount: got %0d want 8", vcnt); end
   endtask
   task automatic test_back_to_back();
      logic [LW-1:0] words[2];
      int idx = 0, vcnt = 0, first = -1, lastv = -1;
      int sofs[$];
      logic acc;
      words[0] = $urandom;
      words[1] = $urandom;
      for (int c = 0; c < 22; c++) begin
         drive(1'b1, idx < 2, words[idx < 2 ? idx : 1], 1'b0);
         total++; if (ready_in !== exp_rdy) begin bad++; $display("FAIL b2b ready c=%0d: got %b want %b", c, ready_in, exp_rdy); end
         acc = (idx < 2) && exp_rdy;
         tick();
         total++; if ({data_out, valid_out, sof, busy} !== {exp_dout, exp_v, exp_sof, exp_busy}) begin bad++; $display("FAIL b2b out c=%0d: got %b want %b", c, {data_out, valid_out, sof, busy}, {exp_dout, exp_v, exp_sof, exp_busy}); end
         if (acc) idx++;
         if (valid_out) begin vcnt++; lastv = c; if (first < 0) first = c; end
         if (sof) sofs.push_back(c - first);
      end
      total++; if (vcnt !== 16 || lastv - first !== 15) begin bad++; $display("FAIL b2b vcount: got %0d span %0d want 16 span 15", vcnt, lastv - first); end
      total++; if (sofs.size() != 2 || sofs[0] != 0 || sofs[1] != 8) begin bad++; $display("FAIL b2b sof: got %0d pulses want 2 at 0,8", sofs.size()); end
   endtask
   task automatic test_enb_stall();
      drive(1'b1, 1'b1, $urandom, 1'b0);
      tick();
      for (int c = 0; c < 12; c++) begin
         drive(!(c >= 3 && c < 6), 1'b0, '0, 1'b0);
         total++; if (ready_in !== exp_rdy) begin bad++; $display("FAIL stall ready c=%0d: got %b want %b", c, ready_in, exp_rdy); end
         tick();
         total++; if ({data_out, valid_out, sof, busy} !== {exp_dout, exp_v, exp_sof, exp_busy}) begin bad++; $display("FAIL stall out c=%0d: got %b want %b", c, {data_out, valid_out, sof, busy}, {exp_dout, exp_v, exp_sof, exp_busy}); end
      end
   endtask
   task automatic test_reset_mid_word();
      int vcnt = 0;
      drive(1'b1, 1'b1, $urandom, 1'b0);
      tick();
      drive(1'b1, 1'b1, $urandom, 1'b0);
      tick();
      for (int c = 0; c < 4; c++) begin drive(1'b1, 1'b0, '0, 1'b0); tick(); end
      drive(1'b1, 1'b0, '0, 1'b1);
      tick();
      total++; if ({data_out, valid_out, sof, busy} !== 7'b0) begin bad++; $display("FAIL midreset out: got %b want 0", {data_out, valid_out, sof, busy}); end
      for (int c = 0; c < 12; c++) begin
         drive(1'b1, 1'b0, '0, 1'b0);
         tick();
         total++; if ({data_out, valid_out, sof, busy} !== {exp_dout, exp_v, exp_sof, exp_busy}) begin bad++; $display("FAIL midreset after c=%0d: got %b want %b", c, {data_out, valid_out, sof, busy}, {exp_dout, exp_v, exp_sof, exp_busy}); end
         if (valid_out) vcnt++;
      end
      total++; if (vcnt !== 0) begin bad++; $display("FAIL midreset leftover: got %0d want 0", vcnt); end
   endtask
   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         drive($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 6, $urandom, $urandom_range(0, 99) == 0);
         total++; if (ready_in !== exp_rdy) begin bad++; $display("FAIL random ready c=%0d: got %b want %b", c, ready_in, exp_rdy); end
         tick();
         total++; if ({data_out, valid_out, sof, busy} !== {exp_dout, exp_v, exp_sof, exp_busy}) begin bad++; $display("FAIL random out c=%0d: got %b want %b", c, {data_out, valid_out, sof, busy}, {exp_dout, exp_v, exp_sof, exp_busy}); end
      end
   endtask
   task automatic test_idle_pattern();
      logic [7:0] idle = 8'hBC;
      drive(1'b1, 1'b0, '0, 1'b1);
      tick();
      for (int k = 0; k < 24; k++) begin
         drive(1'b1, 1'b0, '0, 1'b0);
         tick();
         total++; if ({data_out, valid_out, sof} !== {{L{idle[7 - k % 8]}}, 2'b00}) begin bad++; $display("FAIL idle k=%0d: got %b want %b", k, {data_out, valid_out, sof}, {{L{idle[7 - k % 8]}}, 2'b00}); end
      end
   endtask
   initial begin
      test_reset();
`ifdef P2S_IDLE_PATTERN_EN
      test_idle_pattern();
`else
      test_single_word();
      test_back_to_back();
      test_enb_stall();
      test_reset_mid_word();
      test_random();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
